// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/MEM requester and RAM handshake bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              mem_stall;
    logic              flush;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush,
               ram_rdata, ram_ready,
        output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
               ram_req, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush,
               ram_rdata, ram_ready,
        input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
               ram_req, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    state_t            r_state, w_state_nxt;
    logic              r_ram_req, w_ram_req_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic              r_if_valid, w_if_valid_nxt;
    logic              r_mem_valid, w_mem_valid_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
    logic [3:0]        r_starve_cnt, w_starve_nxt;
    logic              r_discard, w_discard_nxt;
    logic              w_mem_win;
    logic              w_if_win;

    // MEM has priority unless IF has already been passed over MAX_STARVE times
    assign w_mem_win = bus.mem_req && !(bus.if_req && (r_starve_cnt == STARVE_LIM));
    assign w_if_win  = bus.if_req && !bus.flush;

    always_comb begin
        w_state_nxt     = r_state;
        w_ram_req_nxt   = r_ram_req;
        w_ram_we_nxt    = r_ram_we;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_if_valid_nxt  = 1'b0;
        w_mem_valid_nxt = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;
        w_starve_nxt    = r_starve_cnt;
        w_discard_nxt   = r_discard;

        case (r_state)
            IDLE: begin
                if (w_mem_win) begin
                    w_state_nxt     = MEM_XFER;
                    w_ram_req_nxt   = 1'b1;
                    w_ram_we_nxt    = bus.mem_we;
                    w_ram_addr_nxt  = bus.mem_addr;
                    w_ram_wdata_nxt = bus.mem_wdata;
                    if (bus.if_req && (r_starve_cnt != STARVE_LIM)) begin
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    end
                end else if (w_if_win) begin
                    w_state_nxt    = IF_XFER;
                    w_ram_req_nxt  = 1'b1;
                    w_ram_we_nxt   = 1'b0;
                    w_ram_addr_nxt = bus.if_addr;
                    w_starve_nxt   = 4'd0;
                    w_discard_nxt  = 1'b0;
                end
            end
            IF_XFER: begin
                if (bus.flush) begin
                    w_discard_nxt = 1'b1;
                end
                // A flushed fetch still runs to completion on the RAM side; only its result is dropped
                if (bus.ram_ready) begin
                    w_state_nxt   = IDLE;
                    w_ram_req_nxt = 1'b0;
                    w_ram_we_nxt  = 1'b0;
                    w_discard_nxt = 1'b0;
                    if (!(r_discard || bus.flush)) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = bus.ram_rdata;
                    end
                end
            end
            MEM_XFER: begin
                if (bus.ram_ready) begin
                    w_state_nxt     = IDLE;
                    w_ram_req_nxt   = 1'b0;
                    w_ram_we_nxt    = 1'b0;
                    w_mem_valid_nxt = 1'b1;
                    if (!r_ram_we) begin
                        w_mem_rdata_nxt = bus.ram_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_ram_req_nxt = 1'b0;
                w_ram_we_nxt  = 1'b0;
            end
        endcase

        if (!bus.if_req) begin
            w_starve_nxt = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ram_req    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_if_valid   <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_starve_cnt <= 4'd0;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ram_req    <= w_ram_req_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_wdata  <= w_ram_wdata_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_mem_valid  <= w_mem_valid_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_mem_rdata  <= w_mem_rdata_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_discard    <= w_discard_nxt;
        end
    end

    assign bus.ram_req   = r_ram_req;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.if_stall  = bus.if_req & ~r_if_valid;
    assign bus.mem_stall = bus.mem_req & ~r_mem_valid;
endmodule
